ysyx_23060203_lsu: RTL and testbench
====================================

// Module: ysyx_23060203_lsu
// PURPOSE
//  Load/store initiator between EXU and the data-memory slave. Accepts one load or store per
//  request, word-aligns the address, generates byte strobes and lane-shifted write data, and
//  issues a valid/ready request. For loads it waits for the read response, then extracts the
//  addressed lane and sign/zero-extends it. One transaction is outstanding at a time.
// PARAMETERS
//  TIMEOUT   256  cycles in S_WAIT before aborting with resp_err=1; 0 disables the watchdog
// PORTS
//  clk            in   1   clock, all state on posedge
//  rstn           in   1   asynchronous active-low reset
//  req_valid      in   1   EXU request valid
//  req_ready      out  1   LSU can accept (high only in S_IDLE)
//  req_wen        in   1   1=store, 0=load
//  req_func       in   3   funct3: LD_BS/LD_HS/LD_W/LD_BU/LD_HU or ST_B/ST_H/ST_W
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-aligned
//  resp_valid     out  1   result valid, held until resp_ready
//  resp_ready     in   1   EXU/WBU accepts result
//  resp_rdata     out  32  extended load data (0 for stores)
//  resp_err       out  1   misaligned, slave error or timeout
//  mem_valid      out  1   memory request valid
//  mem_ready      in   1   slave accepts request
//  mem_wen        out  1   write request
//  mem_addr       out  32  {req_addr[31:2],2'b00}
//  mem_wdata      out  32  req_wdata << (8*addr[1:0])
//  mem_wstrb      out  4   byte strobes (0 for loads)
//  mem_rvalid     in   1   slave response valid (loads and stores)
//  mem_rready     out  1   LSU accepts response
//  mem_rdata      in   32  word read from mem_addr
//  mem_rerr       in   1   slave error
// BEHAVIOUR
//  - Reset: state=S_IDLE; req_ready=1; resp_valid, resp_err, mem_valid, mem_wen, mem_rready=0;
//    resp_rdata, mem_addr, mem_wdata=0; mem_wstrb=0; watchdog=0. Reset mid-transaction aborts
//    it silently; no response is produced.
//  - States: S_IDLE, S_REQ, S_WAIT, S_DONE. All outputs are registered.
//  - S_IDLE: req_valid -> latch func/addr/wen/wdata. Misaligned (H with addr[0]=1, W with
//    addr[1:0]!=0) -> S_DONE, resp_err=1, rdata=0, no memory access; else -> S_REQ.
//  - S_REQ: mem_valid=1, with addr/wdata/wstrb/wen stable until mem_ready; on mem_ready -> S_WAIT.
//  - S_WAIT: mem_rready=1; watchdog counts. mem_rvalid -> capture mem_rdata/mem_rerr, -> S_DONE.
//    watchdog==TIMEOUT (TIMEOUT!=0) -> S_DONE, resp_err=1. A late response is then discarded.
//  - S_DONE: resp_valid=1, outputs held; resp_ready -> S_IDLE. A new request is accepted the
//    cycle after the handshake (no same-cycle bypass).
//  - Strobes: ST_B 4'b0001<<a[1:0]; ST_H 4'b0011<<a[1:0]; ST_W 4'b1111.
//  - Load extract: lane = mem_rdata >> (8*a[1:0]); LD_BS/LD_BU sign/zero-extend lane[7:0];
//    LD_HS/LD_HU sign/zero-extend lane[15:0]; LD_W = mem_rdata. Unknown funct3 is treated as
//    W (load) / ST_W (store).
//  - mem_rerr=1 -> resp_err=1, resp_rdata=0.
//  - Minimum latency: accept at t, mem_valid at t+1, resp_valid at t+3 with zero-wait slave.
//  - Simultaneous mem_ready and mem_rvalid in S_REQ: mem_rvalid is ignored until S_WAIT; the
//    slave must hold it.
// STRUCTURE
//  - funct3 constants (LD_*, ST_*) are shared with the memory model in params/mem.v.
//  - FSM state encodings are local parameters.
//  - Sub-module ysyx_23060203_lsu_align: combinational strobe, wdata shift and load extend
//    (reusable by a future cache).
// TESTING
//  - LD_BS addr 0x80000003, rdata 0x80FF1234 -> mem_addr 0x80000000, resp_rdata 0xFFFFFF80,
//    err=0.
//  - LD_HU addr 0x80000002, rdata 0xBEEF0000 -> resp_rdata 0x0000BEEF.
//  - ST_H addr 0x80000002, wdata 0x0000ABCD -> mem_wstrb 4'b1100, mem_wdata 0xABCD0000.
//  - LD_W addr 0x80000001 -> no mem_valid ever, resp_valid at t+1, err=1.
//  - mem_ready low for 5 cycles then rvalid with resp_ready low for 3 cycles -> mem_* stable,
//    resp held, req_ready low.
//  - TIMEOUT=8, slave never responds -> resp_err=1 after 8 S_WAIT cycles; mid-S_WAIT rstn
//    pulse -> S_IDLE, all outputs at reset values.

Source files
------------

// File: rtl/ysyx_23060203_lsu_pkg.sv
// Shared load/store definitions: funct3 encodings, access sizes and alignment helpers.
package ysyx_23060203_lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] LD_BS = 3'b000;
  localparam logic [2:0] LD_HS = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [2:0] ST_B  = 3'b000;
  localparam logic [2:0] ST_H  = 3'b001;
  localparam logic [2:0] ST_W  = 3'b010;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Unknown funct3 codes fall back to a full-word access.
  function automatic size_t lsu_size(input logic [2:0] func, input logic wen);
    size_t sz;
    sz = SZ_W;
    if (wen) begin
      case (func)
        ST_B:    sz = SZ_B;
        ST_H:    sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (func)
        LD_BS, LD_BU: sz = SZ_B;
        LD_HS, LD_HU: sz = SZ_H;
        default:      sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] alo);
    return ((sz == SZ_H) && alo[0]) || ((sz == SZ_W) && (alo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060203_lsu_align.sv
// Byte-lane steering: store strobes and data shift, load lane extract with sign/zero extension.
module ysyx_23060203_lsu_align
  import ysyx_23060203_lsu_pkg::*;
(
  input  logic [2:0]  func,
  input  logic        wen,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  size_t       sz;
  logic [15:0] lane;

  always_comb begin
    sz        = lsu_size(func, wen);
    lane      = 16'(rdata >> {addr_lo, 3'b000});
    wdata_sh  = wdata << {addr_lo, 3'b000};
    wstrb     = 4'b0000;
    rdata_ext = rdata;
    if (wen) begin
      case (sz)
        SZ_B:    wstrb = 4'b0001 << addr_lo;
        SZ_H:    wstrb = 4'b0011 << addr_lo;
        default: wstrb = 4'b1111;
      endcase
    end
    // func[2] distinguishes the unsigned byte/half loads
    case (sz)
      SZ_B:    rdata_ext = func[2] ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    rdata_ext = func[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060203_lsu.sv
// Single-outstanding load/store initiator between EXU and the data-memory slave.
module ysyx_23060203_lsu
  import ysyx_23060203_lsu_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t          st;
  logic [WD_W-1:0] wdog;
  logic [2:0]      func_q;
  logic [1:0]      alo_q;
  logic            wen_q;

  logic [2:0]      al_func;
  logic [1:0]      al_alo;
  logic            al_wen;
  logic [3:0]      al_wstrb;
  logic [31:0]     al_wdata;
  logic [31:0]     al_rdata;

  // In S_IDLE the aligner sees the incoming request; afterwards, the latched one.
  assign al_func = (st == S_IDLE) ? req_func       : func_q;
  assign al_alo  = (st == S_IDLE) ? req_addr[1:0]  : alo_q;
  assign al_wen  = (st == S_IDLE) ? req_wen        : wen_q;

  ysyx_23060203_lsu_align u_align (
    .func      (al_func),
    .wen       (al_wen),
    .addr_lo   (al_alo),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .wstrb     (al_wstrb),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (st == S_IDLE && req_valid) begin
      func_q <= req_func;
      alo_q  <= req_addr[1:0];
      wen_q  <= req_wen;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      mem_rready <= 1'b0;
      wdog       <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (misaligned(lsu_size(req_func, req_wen), req_addr[1:0])) begin
              st         <= S_DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              st        <= S_REQ;
              mem_valid <= 1'b1;
              mem_wen   <= req_wen;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= al_wdata;
              mem_wstrb <= al_wstrb;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            st         <= S_WAIT;
            mem_valid  <= 1'b0;
            mem_rready <= 1'b1;
            wdog       <= '0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            st         <= S_DONE;
            mem_rready <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= mem_rerr;
            resp_rdata <= (mem_rerr || wen_q) ? '0 : al_rdata;
          end else if (TIMEOUT != 0 && wdog == WD_W'(TIMEOUT)) begin
            st         <= S_DONE;
            mem_rready <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            st         <= S_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// Directed bench for the LSU: aligned loads/stores, misalignment, stalls, timeout and reset abort.
module tb_ysyx_23060203_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_func;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid, mem_rready, mem_rerr;
  logic [31:0] mem_rdata;

  int ncmp = 0;
  int nfail = 0;

  ysyx_23060203_lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata), .mem_rerr(mem_rerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, ".req_ready"}, req_ready, 1'b1);
    chk1({tag, ".resp_valid"}, resp_valid, 1'b0);
    chk1({tag, ".resp_err"}, resp_err, 1'b0);
    chk1({tag, ".mem_valid"}, mem_valid, 1'b0);
    chk1({tag, ".mem_wen"}, mem_wen, 1'b0);
    chk1({tag, ".mem_rready"}, mem_rready, 1'b0);
    chk({tag, ".resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, ".mem_addr"}, mem_addr, 32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'h0);
  endtask

  // One zero-wait transaction; called at a negedge with the LSU idle.
  task automatic xact(input string tag, input logic wen, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                      input logic rerr, input logic [31:0] exp_rd, input logic exp_err,
                      input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    req_valid = 1'b1; req_wen = wen; req_func = f; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    chk1({tag, ".mem_valid"}, mem_valid, 1'b1);
    chk1({tag, ".mem_wen"}, mem_wen, wen);
    chk1({tag, ".req_ready"}, req_ready, 1'b0);
    chk({tag, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
    if (wen) chk({tag, ".mem_wdata"}, mem_wdata, exp_wd);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk1({tag, ".mem_valid_drop"}, mem_valid, 1'b0);
    chk1({tag, ".mem_rready"}, mem_rready, 1'b1);
    mem_rvalid = 1'b1; mem_rdata = rd; mem_rerr = rerr;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rerr = 1'b0;
    chk1({tag, ".resp_valid"}, resp_valid, 1'b1);
    chk({tag, ".resp_rdata"}, resp_rdata, exp_rd);
    chk1({tag, ".resp_err"}, resp_err, exp_err);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk1({tag, ".resp_valid_drop"}, resp_valid, 1'b0);
    chk1({tag, ".req_ready_back"}, req_ready, 1'b1);
  endtask

  initial begin
    int k;
    rstn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_func = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rerr = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rstn = 1'b1;
    @(negedge clk);

    xact("ld_bs", 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1'b0,
         32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0);
    xact("ld_hu", 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 1'b0,
         32'h0000_BEEF, 1'b0, 4'b0000, 32'h0);
    xact("st_h", 1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 1'b0,
         32'h0, 1'b0, 4'b1100, 32'hABCD_0000);
    xact("st_b", 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00EF, 32'h0, 1'b0,
         32'h0, 1'b0, 4'b0010, 32'h0000_EF00);
    xact("ld_hs", 1'b0, 3'b001, 32'h8000_0000, 32'h0, 32'h1234_8001, 1'b0,
         32'hFFFF_8001, 1'b0, 4'b0000, 32'h0);
    xact("ld_bu", 1'b0, 3'b100, 32'h8000_0001, 32'h0, 32'h0000_9A00, 1'b0,
         32'h0000_009A, 1'b0, 4'b0000, 32'h0);
    xact("ld_w", 1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0,
         32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0);
    xact("ld_unk", 1'b0, 3'b111, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 1'b0,
         32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0);
    xact("ld_rerr", 1'b0, 3'b010, 32'h8000_000C, 32'h0, 32'h1111_2222, 1'b1,
         32'h0, 1'b1, 4'b0000, 32'h0);

    // misaligned word load: immediate error response, no memory access
    req_valid = 1'b1; req_wen = 1'b0; req_func = 3'b010; req_addr = 32'h8000_0001;
    @(negedge clk);
    req_valid = 1'b0;
    chk1("mis.resp_valid", resp_valid, 1'b1);
    chk1("mis.resp_err", resp_err, 1'b1);
    chk("mis.resp_rdata", resp_rdata, 32'h0);
    chk1("mis.mem_valid", mem_valid, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk1("mis.mem_valid_after", mem_valid, 1'b0);
    chk1("mis.req_ready", req_ready, 1'b1);

    // slave stalls the request for 5 cycles, then EXU stalls the response for 3
    req_valid = 1'b1; req_wen = 1'b1; req_func = 3'b010;
    req_addr = 32'h8000_0010; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk1("stall.mem_valid", mem_valid, 1'b1);
      chk("stall.mem_addr", mem_addr, 32'h8000_0010);
      chk("stall.mem_wdata", mem_wdata, 32'h1234_5678);
      chk("stall.mem_wstrb", 32'(mem_wstrb), 32'hF);
      chk1("stall.req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("hold.resp_valid", resp_valid, 1'b1);
      chk1("hold.resp_err", resp_err, 1'b0);
      chk("hold.resp_rdata", resp_rdata, 32'h0);
      chk1("hold.req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk1("hold.resp_valid_drop", resp_valid, 1'b0);
    chk1("hold.req_ready_back", req_ready, 1'b1);

    // slave accepts but never responds: watchdog aborts
    req_valid = 1'b1; req_wen = 1'b0; req_func = 3'b010; req_addr = 32'h8000_0020;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk1("to.mem_rready", mem_rready, 1'b1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        k = i;
        break;
      end
    end
    chk1("to.window", (k > 8) && (k <= 10), 1'b1);
    chk1("to.resp_err", resp_err, 1'b1);
    chk("to.resp_rdata", resp_rdata, 32'h0);
    chk1("to.mem_rready", mem_rready, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk1("late.resp_valid", resp_valid, 1'b0);
    chk1("late.req_ready", req_ready, 1'b1);

    // reset pulse while waiting for the response
    req_valid = 1'b1; req_wen = 1'b0; req_func = 3'b010; req_addr = 32'h8000_0030;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_mid.in_wait", mem_rready, 1'b1);
    rstn = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rstn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk1("rst_mid.no_resp", resp_valid, 1'b0);
    chk1("rst_mid.req_ready", req_ready, 1'b1);

    xact("post_rst", 1'b0, 3'b001, 32'h8000_0042, 32'h0, 32'h8765_4321, 1'b0,
         32'hFFFF_8765, 1'b0, 4'b0000, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no end of sequence, expected $finish before 200000");
    $fatal(1, "bench time limit");
  end

endmodule
